integrate_dump: RTL
===================

# integrate_dump

Integrate-and-dump decimator for the receive sample path. It sums a fixed power-of-two block of signed input samples and emits the rounded block average with a one-cycle valid strobe. `out_data` and `out_valid` connect directly to the D and ce inputs of the downstream parametric register stage, so that stage captures exactly one averaged sample per block.

## Interface
- `W`, 16: signed sample width of `in_data` and `out_data`.
- `LOG2_DEC`, 3: log2 of the decimation ratio. Allowed range is 0..8; DEC = 2^LOG2_DEC.
- `clk`, input, 1: single clock. All logic is rising-edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `clr`, input, 1: synchronous window restart. Discards the partial sum.
- `in_valid`, input, 1: `in_data` is accepted on this cycle. There is no backpressure.
- `in_data`, input, W: signed two's-complement sample.
- `out_valid`, output, 1: one-cycle pulse when `out_data` is updated.
- `out_data`, output, W: signed rounded block average, held between pulses.
- `phase`, output, max(LOG2_DEC,1): number of samples accepted in the current window.

## Operation
- Accumulator `acc` is W+LOG2_DEC bits, signed. It cannot overflow for any input sequence.
- FILL behaviour: while `in_valid` is high and `phase` < DEC-1:
  - acc ← acc + sext(`in_data`)
  - `phase` ← `phase` + 1
- DUMP behaviour: while `in_valid` is high and `phase` = DEC-1:
  - S = acc + `in_data`
  - `out_data` ← (S + 2^(LOG2_DEC-1)) >>> LOG2_DEC, an arithmetic shift. This rounds half toward +inf.
  - `out_valid` ← 1; acc ← 0; `phase` ← 0.
- Rounding constant: it is 0 when LOG2_DEC = 0, which makes the block a 1-cycle pass-through.
- Result range: the result always fits W bits, so no saturation logic is required.
- Cycles with `in_valid` low: hold acc and `phase`; `out_valid` ← 0.
- `clr` high:
  - acc ← 0, `phase` ← 0, `out_valid` ← 0.
  - `clr` has priority over `in_valid`. A sample presented in the same cycle is discarded, including a would-be DUMP sample.
  - `out_data` keeps its last value.
- `rst` high, at any time including mid-window:
  - Immediately forces acc = 0, `phase` = 0, `out_valid` = 0, `out_data` = 0.
  - The first window after deassertion starts at sample 0.
- Reset values: `out_valid` 0, `out_data` 0, `phase` 0.

## Timing
- Latency: `out_valid` rises on the clock edge that accepts the DEC-th sample, and is visible for exactly the following cycle.
- `out_valid` is never high on two consecutive cycles when DEC ≥ 2. It may be when DEC = 1 and `in_valid` is continuously high.
- `out_data` changes only on the edge that sets `out_valid`. It is stable during the whole `out_valid` cycle and afterwards.
- Throughput: one input per cycle, and one output per DEC accepted inputs. Gaps in `in_valid` stretch the window without loss.
- Reset: `rst` deassertion is assumed synchronized to `clk` upstream. The first sample can be accepted on the first edge after release.

## Structure
- Shared package `sonar_pkg`:
  - function `round_shift(S, LOG2_DEC)` for rounded arithmetic right shift.
  - constant `SAMPLE_W` = 16 as the default for `W`.
- Single module with no sub-modules.
- Counter, accumulator and output register live in one clocked process with asynchronous reset.
- `phase` is the counter register itself, not a copy.

## Test plan
All scenarios use W=16, LOG2_DEC=3.
- Constant input: 8 samples of 100 with `in_valid` held high → exactly one `out_valid` pulse, in the cycle after the 8th sample, with `out_data` = 100. `phase` returns to 0.
- Rounding: block sum 4 (e.g. 4,0,0,0,0,0,0,0) → 1. Block sum 3 → 0. Block sum −4 → 0. Block sum −5 → −1.
- Extremes: 8 × 32767 → 32767. 8 × −32768 → −32768. Neither case wraps.
- Gapped input: `in_valid` high every 3rd cycle, samples 1..8 → `out_data` = 5 (36/8 = 4.5, rounded up). The pulse comes one cycle after the 8th valid sample.
- Clear handling:
  - 5 samples of 7, then `clr`, then 8 samples of 10 → a single output of 10.
  - `clr` coincident with the 8th sample → no `out_valid`, and `out_data` unchanged.
- Asynchronous reset: `rst` asserted between edges after 6 samples → `out_data` = 0 and `phase` = 0 before the next edge. After release, 8 samples of −3 → `out_data` = −3 ((−24+4)>>>3 = −3).

Source files
------------

// File: rtl/sonar_pkg.sv
// sonar_pkg: shared receive-path constants and a rounded arithmetic right-shift helper.
package sonar_pkg;
  localparam int SAMPLE_W = 16;
  // Arithmetic right shift by sh with round-half-toward-+inf; a shift of 0 passes s through.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] s, input int unsigned sh);
    return sh == 0 ? s : (s + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction
endpackage

// File: rtl/integrate_dump.sv
// integrate_dump: sums 2^LOG2_DEC signed samples and emits the rounded block average.
// Ports: clk, rst (async, active high), clr (sync window restart), in_valid/in_data (sample in),
//        out_valid/out_data (one-cycle strobe with held average), phase (samples in current window).
module integrate_dump
  import sonar_pkg::*;
#(
  parameter int W = SAMPLE_W,
  parameter int LOG2_DEC = 3
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       clr,
  input  logic                                       in_valid,
  input  logic signed [W-1:0]                        in_data,
  output logic                                       out_valid,
  output logic signed [W-1:0]                        out_data,
  output logic [((LOG2_DEC > 0) ? LOG2_DEC : 1)-1:0] phase
);
  localparam int AW = W + LOG2_DEC;
  localparam int PW = (LOG2_DEC > 0) ? LOG2_DEC : 1;
  localparam logic [PW-1:0] LAST = PW'((1 << LOG2_DEC) - 1);
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sum;
  logic signed [W-1:0] avg;
  // AW bits hold DEC full-scale samples, so the running sum never wraps.
  assign sum = acc + AW'(in_data);
  assign avg = W'(round_shift(64'(sum), LOG2_DEC));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      phase     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clr) begin
      acc       <= '0;
      phase     <= '0;
      out_valid <= 1'b0;
    end else if (in_valid && phase == LAST) begin
      acc       <= '0;
      phase     <= '0;
      out_valid <= 1'b1;
      out_data  <= avg;
    end else if (in_valid) begin
      acc       <= sum;
      phase     <= phase + 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
    end
  end
endmodule
